// File: rtl/dm_access_arbiter_if.sv
// Bundle of the M-stage, debug/DMA and single-port memory signals around dm_access_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dm_access_arbiter_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// Shares the single-port data memory between pipeline port M and debug/DMA port D.
// Latency: MEM_LAT+1 cycles request-to-completion uncontended; one access per MEM_LAT+2 cycles.
// Backpressure: M frozen by combinational m_stall, D held until d_ack; DM_ARB_RR_EN selects round-robin.
module dm_access_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    dm_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t          state;
    logic            owner_d;
    logic [LW-1:0]   lat_cnt;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     m_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            d_ack_q;
    logic            mem_en_q;
    logic            mem_we_q;
    logic            any_req;
    logic            grant_d;

`ifdef DM_ARB_RR_EN
    logic            last_d;
`else
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0]   wait_cnt;
`endif

    // Contention resolution only; a lone request always wins.
    always_comb begin
        any_req = bus.m_req | bus.d_req;
`ifdef DM_ARB_RR_EN
        grant_d = bus.d_req & (~bus.m_req | ~last_d);
`else
        grant_d = bus.d_req & (~bus.m_req | (wait_cnt == WW'(MAX_WAIT)));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            lat_cnt   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            m_rdata_q <= '0;
            d_rdata_q <= '0;
            d_ack_q   <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef DM_ARB_RR_EN
            last_d    <= 1'b1;
`else
            wait_cnt  <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d  <= grant_d;
                        we_q     <= grant_d ? bus.d_we    : bus.m_we;
                        addr_q   <= grant_d ? bus.d_addr  : bus.m_addr;
                        wdata_q  <= grant_d ? bus.d_wdata : bus.m_wdata;
                        mem_we_q <= grant_d ? bus.d_we    : bus.m_we;
                        lat_cnt  <= LW'(MEM_LAT - 1);
                        mem_en_q <= 1'b1;
                        state    <= BUSY;
`ifdef DM_ARB_RR_EN
                        last_d   <= grant_d;
`else
                        if (grant_d)
                            wait_cnt <= '0;
                        else if (bus.d_req && wait_cnt != WW'(MAX_WAIT))
                            wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        mem_en_q <= 1'b0;
                        state    <= DONE;
                        if (owner_d) begin
                            d_rdata_q <= bus.mem_rdata;
                            d_ack_q   <= 1'b1;
                        end else begin
                            m_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The stall drops in the DONE cycle itself so M sees its data with no bubble.
    assign bus.m_stall   = bus.m_req & ~((state == DONE) & ~owner_d);
    assign bus.m_rdata   = m_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q & ~we_q ? 1'b0 : mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
module tb_dm_access_arbiter;
    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_access_arbiter_if bus ();

    dm_access_arbiter #(.MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] rd_q;

    exp_t m_exp[$];
    exp_t d_exp[$];
    bit   order_log[$];
    int   dack_cnt = 0;
    int   we_cycles = 0;
    bit   prev_dack = 1'b0;

    // Memory with one register stage: data valid MEM_LAT cycles after the first enable.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            rd_q <= mem[bus.mem_addr[9:2]];
        end
    end
    assign bus.mem_rdata = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops the expected response whenever a completion is visible.
    always @(negedge clk) begin
        if (reset) begin
            bit m_done, d_done;
            exp_t e;
            m_done = bus.m_req && !bus.m_stall;
            d_done = bus.d_ack;
            if (bus.mem_we) we_cycles++;
            if (m_done || d_done) chk("dual_completion", 32'(m_done && d_done), 0);
            if (m_done) begin
                chk("m_expected", 32'(m_exp.size() != 0), 1);
                if (m_exp.size() != 0) begin
                    e = m_exp.pop_front();
                    if (!e.we) chk("m_rdata", bus.m_rdata, e.data);
                end
                order_log.push_back(1'b0);
            end
            if (d_done) begin
                chk("dack_pulse", 32'(prev_dack), 0);
                chk("d_expected", 32'(d_exp.size() != 0), 1);
                if (d_exp.size() != 0) begin
                    e = d_exp.pop_front();
                    if (!e.we) chk("d_rdata", bus.d_rdata, e.data);
                end
                order_log.push_back(1'b1);
            end
        end
        if (bus.d_ack) dack_cnt++;
        prev_dack = bus.d_ack;
    end

    task automatic m_access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int n;
        e.we = we;
        e.data = ref_mem[addr[9:2]];
        if (we) ref_mem[addr[9:2]] = wd;
        m_exp.push_back(e);
        bus.m_req = 1'b1; bus.m_we = we; bus.m_addr = addr; bus.m_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.m_stall && n < 100);
        if (n >= 100) chk("m_timeout", 1, 0);
        @(posedge clk); #1;
        bus.m_req = 1'b0;
    endtask

    task automatic d_access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int n;
        e.we = we;
        e.data = ref_mem[addr[9:2]];
        if (we) ref_mem[addr[9:2]] = wd;
        d_exp.push_back(e);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.d_ack && n < 100);
        if (n >= 100) chk("d_timeout", 1, 0);
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    initial begin
        bit exp_order[$];
        int n_d;
        int c;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        bus.m_req = 0; bus.m_we = 0; bus.m_addr = 0; bus.m_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_m_stall", 32'(bus.m_stall), 0);
        chk("rst_d_ack", 32'(bus.d_ack), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);

        // Reset asserted mid-BUSY of a D write drops it without completion
        @(posedge clk); #1;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h300; bus.d_wdata = 32'h55;
        @(posedge clk); #1;
        chk("midrst_busy_en", 32'(bus.mem_en), 1);
        chk("midrst_busy_we", 32'(bus.mem_we), 1);
        reset = 1'b0;
        #1;
        chk("midrst_en_low", 32'(bus.mem_en), 0);
        chk("midrst_we_low", 32'(bus.mem_we), 0);
        bus.d_req = 0;
        c = dack_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_dack", 32'(dack_cnt), 32'(c));
        chk("midrst_idle_en", 32'(bus.mem_en), 0);
        chk("midrst_no_commit", mem[8'hC0], 0);
        chk("midrst_d_rdata", bus.d_rdata, 0);
        chk("midrst_m_rdata", bus.m_rdata, 0);

        // M read cycle-by-cycle timing
        @(posedge clk); #1;
        m_exp.push_back('{we: 1'b0, data: 32'hDEADBEEF});
        bus.m_req = 1; bus.m_we = 0; bus.m_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mrd_stall_c%0d", i), 32'(bus.m_stall), (i < 3) ? 1 : 0);
            chk($sformatf("mrd_en_c%0d", i), 32'(bus.mem_en), (i == 1 || i == 2) ? 1 : 0);
        end
        chk("mrd_data", bus.m_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        bus.m_req = 0;

        // D write: single write strobe, ack in cycle 3; then read it back
        c = we_cycles;
        d_exp.push_back('{we: 1'b1, data: 32'h0});
        ref_mem[8] = 32'h12345678;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("dwr_ack_c%0d", i), 32'(bus.d_ack), (i == 3) ? 1 : 0);
        end
        @(posedge clk); #1;
        bus.d_req = 0;
        chk("dwr_we_cycles", 32'(we_cycles - c), 1);
        d_access(0, 32'h20, 0);

        // Continuous contention: compute expected grant order from the priority rule
        begin
            int rm, rd, w;
            bit last_d;
            rm = 8; rd = 2; w = 0; last_d = 1'b1;
            exp_order.delete();
            while (rm + rd > 0) begin
                bit g;
                if (rm > 0 && rd > 0) begin
`ifdef DM_ARB_RR_EN
                    g = !last_d;
`else
                    g = (w == MAX_WAIT);
`endif
                end else begin
                    g = (rm == 0);
                end
                if (g) begin w = 0; rd--; end
                else begin if (rd > 0 && w < MAX_WAIT) w++; rm--; end
                last_d = g;
                exp_order.push_back(g);
            end
        end
        order_log.delete();
        fork
            for (int i = 0; i < 8; i++) m_access(0, 32'(i) << 2, 0);
            for (int i = 0; i < 2; i++) d_access(0, 32'h100 + (32'(i) << 2), 0);
        join
        chk("cont_count", 32'(order_log.size()), 32'(exp_order.size()));
        n_d = 0;
        for (int i = 0; i < exp_order.size() && i < order_log.size(); i++) begin
            chk($sformatf("cont_grant%0d", i), 32'(order_log[i]), 32'(exp_order[i]));
            if (order_log[i]) n_d++;
        end
        chk("cont_dacks", 32'(n_d), 2);

        // M drops its request during BUSY; D arriving then is served only after DONE
        ref_mem[16] = 32'hA5A50001;
        bus.m_req = 1; bus.m_we = 1; bus.m_addr = 32'h40; bus.m_wdata = 32'hA5A50001;
        @(posedge clk); #1;
        bus.m_req = 0;
        d_exp.push_back('{we: 1'b0, data: ref_mem[8'h50]});
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h140;
        @(negedge clk);
        chk("drop_stall", 32'(bus.m_stall), 0);
        c = 1;
        while (!bus.d_ack && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("drop_dack_cycle", 32'(c), 7);
        @(posedge clk); #1;
        bus.d_req = 0;
        m_access(0, 32'h40, 0);

        // Randomized traffic on disjoint address ranges
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                m_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
            end
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                d_access(1'($urandom_range(0, 1)), 32'h100 + (32'($urandom_range(0, 63)) << 2), $urandom);
            end
        join
        repeat (3) @(posedge clk);
        chk("m_exp_drained", 32'(m_exp.size()), 0);
        chk("d_exp_drained", 32'(d_exp.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
